da_cache: RTL and testbench



---
 rtl/da_cache_pkg.sv | 27 ++
 rtl/da_cache_if.sv | 19 +
 rtl/buffered_ram_tdp.sv | 34 +++
 rtl/da_cache.sv | 223 ++++++++++++++++++++++
 tb/tb_da_cache.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/da_cache_pkg.sv
// -----------------------------------------------------------------------------
// da_cache_pkg
// Shared widths, logic levels and reader FSM encodings for the DAC playback
// cache. Imported by the interface, the cache top and the bench.
// -----------------------------------------------------------------------------
package da_cache_pkg;

  localparam int DA_DATA_NBIT     = 16;  // DAC sample width (low bits of a word)
  localparam int USB_DATA_NBIT    = 8;   // USB byte width
  localparam int DA_CHE_ADDR_NBIT = 9;   // words per bank = 2**DA_CHE_ADDR_NBIT
  localparam int DA_CHE_DATA_NBIT = 24;  // packed word, three USB bytes

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } rd_state_e;

  // Rising edge seen on a 3-flop sampling chain (oldest sample in bit 2).
  function automatic logic rise_seen(input logic [2:0] p);
    return (p[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/da_cache_if.sv
// -----------------------------------------------------------------------------
// da_cache_if
// USB FIFO byte-stream handshake into the playback cache.
//   usb_wr    : byte strobe, one byte per clk while high (master -> slave)
//   usb_data  : byte, MSB byte of each packed word first  (master -> slave)
//   usb_ready : next byte will be accepted                (slave -> master)
// -----------------------------------------------------------------------------
interface da_cache_if #(
  parameter int DATA_NBIT = da_cache_pkg::USB_DATA_NBIT
);

  logic                 usb_wr;
  logic [DATA_NBIT-1:0] usb_data;
  logic                 usb_ready;

  modport master (output usb_wr, output usb_data, input usb_ready);
  modport slave  (input usb_wr, input usb_data, output usb_ready);

endinterface

// File: rtl/buffered_ram_tdp.sv
// -----------------------------------------------------------------------------
// buffered_ram_tdp
// Two-port RAM on a single clock, registered read data on both ports
// (1-cycle read latency). Each port can write; if both ports write the same
// address in one cycle, port B wins.
//   clk                  : clock
//   wea/addra/dina/douta : port A write enable, address, write data, read data
//   web/addrb/dinb/doutb : port B write enable, address, write data, read data
// -----------------------------------------------------------------------------
module buffered_ram_tdp #(
  parameter int ADDR_NBIT = 10,
  parameter int DATA_NBIT = 24
) (
  input  logic                 clk,
  input  logic                 wea,
  input  logic [ADDR_NBIT-1:0] addra,
  input  logic [DATA_NBIT-1:0] dina,
  output logic [DATA_NBIT-1:0] douta,
  input  logic                 web,
  input  logic [ADDR_NBIT-1:0] addrb,
  input  logic [DATA_NBIT-1:0] dinb,
  output logic [DATA_NBIT-1:0] doutb
);

  logic [DATA_NBIT-1:0] mem [2**ADDR_NBIT];

  always_ff @(posedge clk) begin
    if (wea) mem[addra] <= dina;
    if (web) mem[addrb] <= dinb;
    douta <= mem[addra];
    doutb <= mem[addrb];
  end

endmodule

// File: rtl/da_cache.sv
// -----------------------------------------------------------------------------
// da_cache
// Playback cache: packs USB bytes three at a time into 24-bit words, stores
// them in a two-bank ping-pong RAM, and once armed by a sync rising edge hands
// one 16-bit sample to the DAC per spclk rising edge.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | block disabled or just enabled; da_valid low
//   ARMED | enabled, waiting for a sync rising edge
//   RUN   | da_valid high; every spclk edge consumes one word or underruns
//
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   en        : enable; low flushes both banks and returns to IDLE
//   sync      : async frame start, rising edge arms playback
//   spclk     : async DAC sample clock, rising edge consumes a sample
//   usb       : byte stream handshake (da_cache_if.slave)
//   da_data   : sample to DAC, 4 clk after the spclk edge reaches the pin
//   da_valid  : high in RUN
//   switch    : bank currently being read
//   underrun  : sticky, spclk edge in RUN with the read bank not full
//   overflow  : sticky, byte offered while usb_ready low
// -----------------------------------------------------------------------------
module da_cache #(
  parameter int DA_CHE_ADDR_NBIT = da_cache_pkg::DA_CHE_ADDR_NBIT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 sync,
  input  logic                                 spclk,
  da_cache_if.slave                            usb,
  output logic [da_cache_pkg::DA_DATA_NBIT-1:0] da_data,
  output logic                                 da_valid,
  output logic                                 switch,
  output logic                                 underrun,
  output logic                                 overflow
);

  import da_cache_pkg::*;

  localparam int RAM_AW = DA_CHE_ADDR_NBIT + 1;
  localparam logic [DA_CHE_ADDR_NBIT-1:0] LAST_ADDR = '1;

  // input sampling
  logic [2:0] p_sync;
  logic [2:0] p_spclk;
  logic       sync_rise;
  logic       sp_rise;

  // reader FSM
  rd_state_e state_q;
  rd_state_e state_d;

  // packer / writer
  logic [1:0]                    byte_cnt_q;
  logic [DA_CHE_DATA_NBIT-1:0]   word_q;
  logic                          wbank_q;
  logic [DA_CHE_ADDR_NBIT-1:0]   waddr_q;
  logic                          wr_en_q;
  logic [RAM_AW-1:0]             wr_addr_q;
  logic                          ready_q;

  // reader datapath
  logic                          rbank_q;
  logic [DA_CHE_ADDR_NBIT-1:0]   raddr_q;
  logic                          rd_pend_q;
  logic [DA_DATA_NBIT-1:0]       da_data_q;
  logic [DA_CHE_DATA_NBIT-1:0]   ram_q;

  // bank flags and status
  logic [1:0] full_q;
  logic [1:0] full_d;
  logic       underrun_q;
  logic       overflow_q;

  // per-cycle events
  logic accept;
  logic word_done;
  logic wr_last;
  logic rd_fire;
  logic rd_hit;
  logic rd_last;

  logic [DA_CHE_DATA_NBIT-1:0] unused_ram_qa;
  logic                        unused_bits;

  assign sync_rise = rise_seen(p_sync);
  assign sp_rise   = rise_seen(p_spclk);

  always_ff @(posedge clk) begin
    if (rst) begin
      p_sync  <= '0;
      p_spclk <= '0;
    end else begin
      p_sync  <= {p_sync[1:0], sync};
      p_spclk <= {p_spclk[1:0], spclk};
    end
  end

  // Event decode and bank-flag next state. A writer set and a reader clear
  // always target different banks, so both are applied in the same cycle.
  always_comb begin
    accept    = usb.usb_wr & ready_q;
    word_done = accept & (byte_cnt_q == 2'd2);
    wr_last   = word_done & (waddr_q == LAST_ADDR);
    rd_fire   = (state_q == RUN) & sp_rise;
    rd_hit    = rd_fire & full_q[rbank_q];
    rd_last   = rd_hit & (raddr_q == LAST_ADDR);
    full_d    = full_q;
    if (wr_last) full_d[wbank_q] = HIGH;
    if (rd_last) full_d[rbank_q] = LOW;
  end

  // Packer: the completed word is written the cycle after its third byte,
  // from the latched address, while the next word may already be shifting in.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
      wbank_q    <= LOW;
      waddr_q    <= '0;
      wr_en_q    <= LOW;
      wr_addr_q  <= '0;
    end else begin
      wr_en_q <= word_done;
      if (accept) begin
        word_q     <= {word_q[DA_CHE_DATA_NBIT-USB_DATA_NBIT-1:0], usb.usb_data};
        byte_cnt_q <= word_done ? 2'd0 : byte_cnt_q + 2'd1;
      end
      if (word_done) begin
        wr_addr_q <= {wbank_q, waddr_q};
        waddr_q   <= waddr_q + 1'b1;  // wraps to 0 after the last address
        if (wr_last) wbank_q <= ~wbank_q;
      end
    end
  end

  // Bank flags and ready. Ready looks at the flags already registered, so it
  // trails a flag change by one cycle; the only byte that can slip through in
  // that window is the first of a new word, which is never written to RAM.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      full_q  <= '0;
      ready_q <= LOW;
    end else begin
      full_q  <= full_d;
      ready_q <= ~full_q[wbank_q];
    end
  end

  // Reader: address is issued on the detect cycle, RAM data lands one cycle
  // later and is registered into da_data the cycle after that.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      rbank_q   <= LOW;
      raddr_q   <= '0;
      rd_pend_q <= LOW;
      da_data_q <= '0;
    end else begin
      rd_pend_q <= rd_hit;
      if (rd_pend_q) da_data_q <= ram_q[DA_DATA_NBIT-1:0];
      if (rd_hit) begin
        raddr_q <= raddr_q + 1'b1;
        if (rd_last) rbank_q <= ~rbank_q;
      end
    end
  end

  // Sticky status, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_q <= LOW;
      overflow_q <= LOW;
    end else begin
      if (usb.usb_wr && !ready_q)              overflow_q <= HIGH;
      if (en && rd_fire && !full_q[rbank_q])   underrun_q <= HIGH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = ARMED;
      ARMED:   if (sync_rise) state_d = RUN;
      RUN:     state_d = RUN;   // further sync edges are ignored
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end

  buffered_ram_tdp #(
    .ADDR_NBIT (RAM_AW),
    .DATA_NBIT (DA_CHE_DATA_NBIT)
  ) u_ram (
    .clk   (clk),
    .wea   (wr_en_q),
    .addra (wr_addr_q),
    .dina  (word_q),
    .douta (unused_ram_qa),
    .web   (LOW),
    .addrb ({rbank_q, raddr_q}),
    .dinb  ('0),
    .doutb (ram_q)
  );

  // Upper byte of each packed word and port A read data are not used.
  assign unused_bits = ^{unused_ram_qa, ram_q[DA_CHE_DATA_NBIT-1:DA_DATA_NBIT]};

  assign usb.usb_ready = ready_q;
  assign da_data       = da_data_q;
  assign da_valid      = (state_q == RUN);
  assign switch        = rbank_q;
  assign underrun      = underrun_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_da_cache.sv
// -----------------------------------------------------------------------------
// tb_da_cache
// Directed bench for da_cache with 4 words per bank. Inputs change 1 ns after
// a rising clk edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_da_cache;

  import da_cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sync;
  logic        spclk;
  logic [15:0] da_data;
  logic        da_valid;
  logic        switch;
  logic        underrun;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  logic [15:0] fill_a [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                              16'h1357, 16'h2468, 16'hACE0, 16'hBDF1};
  logic [15:0] fill_b [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] fill_c [8] = '{16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1020,
                              16'h3040, 16'h5060, 16'h7080, 16'h90A0};
  logic [15:0] last_exp;

  da_cache_if #(.DATA_NBIT(8)) usb ();

  da_cache #(.DA_CHE_ADDR_NBIT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .spclk    (spclk),
    .usb      (usb),
    .da_data  (da_data),
    .da_valid (da_valid),
    .switch   (switch),
    .underrun (underrun),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    usb.usb_wr   = 1'b1;
    usb.usb_data = b;
    tick();
    usb.usb_wr   = 1'b0;
  endtask

  task automatic put_word(input logic [15:0] w);
    put_byte(8'h00);
    put_byte(w[15:8]);
    put_byte(w[7:0]);
  endtask

  task automatic sp_pulse();
    spclk = 1'b1;
    repeat (4) tick();
    spclk = 1'b0;
    repeat (2) tick();
  endtask

  task automatic sync_pulse();
    sync = 1'b1;
    repeat (3) tick();
    sync = 1'b0;
    repeat (2) tick();
  endtask

  // One spclk edge: da_data must still hold prev after 3 clk and show exp after 4.
  task automatic sp_read(input string tag, input logic [15:0] prev, input logic [15:0] exp);
    spclk = 1'b1;
    repeat (3) tick();
    check_val({tag, "_hold"}, da_data, prev);
    tick();
    check_val(tag, da_data, exp);
    spclk = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    sync         = 1'b0;
    spclk        = 1'b0;
    usb.usb_wr   = 1'b0;
    usb.usb_data = 8'h00;
    repeat (2) tick();

    check_val("rst_ready",    usb.usb_ready, 0);
    check_val("rst_valid",    da_valid, 0);
    check_val("rst_data",     da_data, 0);
    check_val("rst_switch",   switch, 0);
    check_val("rst_underrun", underrun, 0);
    check_val("rst_overflow", overflow, 0);

    rst = 1'b0;
    en  = 1'b1;
    tick();
    check_val("ready_up", usb.usb_ready, 1);

    // fill both banks
    for (int i = 0; i < 8; i++) put_word(fill_a[i]);
    check_val("ready_at_last_byte", usb.usb_ready, 1);
    tick();
    check_val("ready_fall", usb.usb_ready, 0);

    // spclk before arming is ignored
    sp_pulse();
    sp_pulse();
    check_val("prearm_data",     da_data, 0);
    check_val("prearm_underrun", underrun, 0);
    check_val("prearm_valid",    da_valid, 0);

    // playback of both banks
    sync_pulse();
    check_val("run_valid", da_valid, 1);
    last_exp = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      sp_read($sformatf("play%0d", i), last_exp, fill_a[i]);
      last_exp = fill_a[i];
      if (i == 2) begin
        check_val("switch_before_swap", switch, 0);
        check_val("ready_before_drain", usb.usb_ready, 0);
      end
      if (i == 3) begin
        check_val("switch_after_swap", switch, 1);
        check_val("ready_after_drain", usb.usb_ready, 1);
      end
    end
    check_val("switch_wrap", switch, 0);
    check_val("play_underrun", underrun, 0);

    // underrun with one bank
    for (int i = 0; i < 4; i++) put_word(fill_b[i]);
    for (int i = 0; i < 4; i++) begin
      sp_read($sformatf("ur%0d", i), last_exp, fill_b[i]);
      last_exp = fill_b[i];
    end
    check_val("ur_before", underrun, 0);
    sp_read("ur_hold_last", last_exp, 16'h4444);
    check_val("ur_set",   underrun, 1);
    check_val("ur_valid", da_valid, 1);

    // overflow with both banks full (bank 1 fills first now)
    for (int i = 0; i < 8; i++) put_word(fill_c[i]);
    tick();
    check_val("ov_ready_low", usb.usb_ready, 0);
    check_val("ov_before", overflow, 0);
    put_byte(8'hAA);
    check_val("ov_set", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      sp_read($sformatf("ov_drain%0d", i), last_exp, fill_c[i]);
      last_exp = fill_c[i];
    end
    check_val("ov_ready_back", usb.usb_ready, 1);
    put_word(16'h7788);
    put_word(16'h0001);
    put_word(16'h0002);
    put_word(16'h0003);
    for (int i = 4; i < 8; i++) begin
      sp_read($sformatf("ov_drain%0d", i), last_exp, fill_c[i]);
      last_exp = fill_c[i];
    end
    sp_read("ov_aligned", last_exp, 16'h7788);
    last_exp = 16'h7788;
    check_val("switch_pre_flush", switch, 1);

    // flush with a partial word pending
    put_byte(8'h11);
    put_byte(8'h22);
    en = 1'b0;
    tick();
    check_val("flush_valid",    da_valid, 0);
    check_val("flush_data",     da_data, 0);
    check_val("flush_switch",   switch, 0);
    check_val("flush_ready",    usb.usb_ready, 0);
    check_val("flush_underrun", underrun, 1);
    check_val("flush_overflow", overflow, 1);
    en = 1'b1;
    tick();
    check_val("reen_ready", usb.usb_ready, 1);
    check_val("reen_valid", da_valid, 0);
    put_word(16'hCAFE);
    put_word(16'hBEEF);
    put_word(16'h0004);
    put_word(16'h0005);
    sync_pulse();
    check_val("reen_run", da_valid, 1);
    sp_read("reen_first", 16'h0000, 16'hCAFE);
    sp_read("reen_second", 16'hCAFE, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
